// File: rtl/mag_comp_serial.sv
// Serial MSB-first magnitude comparator: captures two WIDTH-bit operands on start,
// scans one bit per clock, and reports registered lt/gt/eq with a one-cycle done pulse.
module mag_comp_serial #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b;
    logic             r_signed;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic             r_decided, w_decided_nxt;
    logic             r_lt_rec, w_lt_rec_nxt;
    logic             r_gt_rec, w_gt_rec_nxt;
    logic             r_done, w_done_nxt;
    logic             r_lt, w_lt_nxt;
    logic             r_gt, w_gt_nxt;
    logic             r_eq, w_eq_nxt;

    logic [WIDTH-1:0] w_mask;
    logic             w_a_bit, w_b_bit, w_found, w_a_wins, w_capture;

    assign w_mask    = WIDTH'(1'b1) << r_idx;
    assign w_a_bit   = |(r_a & w_mask);
    assign w_b_bit   = |(r_b & w_mask);
    assign w_found   = (r_state == S_SCAN) && !r_decided && (w_a_bit != w_b_bit);
    // The sign bit of a two's-complement operand carries negative weight, so its sense flips.
    assign w_a_wins  = w_a_bit ^ (r_signed & (r_idx == IDX_MSB));
    assign w_capture = (r_state == S_IDLE) && start;

    // Next-state and result computation for the scan FSM.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_decided_nxt = r_decided;
        w_lt_rec_nxt  = r_lt_rec;
        w_gt_rec_nxt  = r_gt_rec;
        w_done_nxt    = 1'b0;
        w_lt_nxt      = r_lt;
        w_gt_nxt      = r_gt;
        w_eq_nxt      = r_eq;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt   = S_SCAN;
                    w_idx_nxt     = IDX_MSB;
                    w_decided_nxt = 1'b0;
                    w_lt_rec_nxt  = 1'b0;
                    w_gt_rec_nxt  = 1'b0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SCAN: begin
                if (w_found) begin
                    w_decided_nxt = 1'b1;
                    w_gt_rec_nxt  = w_a_wins;
                    w_lt_rec_nxt  = !w_a_wins;
                end else begin
                    w_decided_nxt = r_decided;
                end
                if ((EARLY_EXIT && w_found) || (r_idx == '0)) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                    w_lt_nxt    = w_lt_rec_nxt;
                    w_gt_nxt    = w_gt_rec_nxt;
                    w_eq_nxt    = !w_decided_nxt;
                end else begin
                    w_idx_nxt = r_idx - IDX_W'(1'b1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, shadow operands and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_signed  <= 1'b0;
            r_idx     <= '0;
            r_decided <= 1'b0;
            r_lt_rec  <= 1'b0;
            r_gt_rec  <= 1'b0;
            r_done    <= 1'b0;
            r_lt      <= 1'b0;
            r_gt      <= 1'b0;
            r_eq      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_decided <= w_decided_nxt;
            r_lt_rec  <= w_lt_rec_nxt;
            r_gt_rec  <= w_gt_rec_nxt;
            r_done    <= w_done_nxt;
            r_lt      <= w_lt_nxt;
            r_gt      <= w_gt_nxt;
            r_eq      <= w_eq_nxt;
            if (w_capture) begin
                r_a      <= a;
                r_b      <= b;
                r_signed <= signed_mode;
            end else begin
                r_a      <= r_a;
                r_b      <= r_b;
                r_signed <= r_signed;
            end
        end
    end

    assign busy = (r_state == S_SCAN);
    assign done = r_done;
    assign lt   = r_lt;
    assign gt   = r_gt;
    assign eq   = r_eq;

endmodule

// File: tb/tb_mag_comp_serial.sv
// Scoreboard bench for mag_comp_serial: three instances (WIDTH=1, WIDTH=8 early-exit,
// WIDTH=8 fixed latency) share operand buses; each has its own start strobe.
module tb_mag_comp_serial;

    localparam logic [2:0] R_LT = 3'b100;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_EQ = 3'b001;

    typedef struct {
        int         id;
        logic [2:0] res;
        int         edge_n;
    } sb_item_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] a_v, b_v;
    logic       sm;
    logic [2:0] start_v;
    logic [2:0] busy_v, done_v, lt_v, gt_v, eq_v;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    sb_item_t   sb_q[$];
    logic [2:0] last_res [3];

    mag_comp_serial #(.WIDTH(1), .EARLY_EXIT(1'b1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .signed_mode(sm),
        .a(a_v[0:0]), .b(b_v[0:0]), .busy(busy_v[0]), .done(done_v[0]),
        .lt(lt_v[0]), .gt(gt_v[0]), .eq(eq_v[0]));

    mag_comp_serial #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_w8e (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .signed_mode(sm),
        .a(a_v), .b(b_v), .busy(busy_v[1]), .done(done_v[1]),
        .lt(lt_v[1]), .gt(gt_v[1]), .eq(eq_v[1]));

    mag_comp_serial #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_w8f (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .signed_mode(sm),
        .a(a_v), .b(b_v), .busy(busy_v[2]), .done(done_v[2]),
        .lt(lt_v[2]), .gt(gt_v[2]), .eq(eq_v[2]));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Monitor: pops an expectation on every done, otherwise results must hold.
    always @(negedge clk) begin
        sb_item_t it;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) last_res[i] = 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (done_v[i]) begin
                    if (sb_q.size() == 0 || sb_q[0].id != i) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done dut%0d: got done=1 expected no done (edge %0d)", i, cyc);
                    end else begin
                        it = sb_q.pop_front();
                        chk($sformatf("result_dut%0d", i), int'({lt_v[i], gt_v[i], eq_v[i]}), int'(it.res));
                        chk($sformatf("done_edge_dut%0d", i), cyc, it.edge_n);
                        last_res[i] = it.res;
                    end
                end else begin
                    chk($sformatf("hold_dut%0d", i), int'({lt_v[i], gt_v[i], eq_v[i]}), int'(last_res[i]));
                end
            end
        end
    end

    task automatic issue(input int id, input logic [7:0] av, input logic [7:0] bv,
                         input logic smv, input logic [2:0] er, input int lat);
        sb_item_t it;
        @(negedge clk);
        a_v = av;
        b_v = bv;
        sm = smv;
        start_v = 3'b000;
        start_v[id] = 1'b1;
        @(posedge clk);
        #1;
        start_v = 3'b000;
        it.id = id;
        it.res = er;
        it.edge_n = cyc + lat;
        sb_q.push_back(it);
    endtask

    task automatic wait_idle(input int id);
        for (int n = 0; n < 40 && sb_q.size() != 0; n++) @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout dut%0d: got %0d pending expected 0", id, sb_q.size());
            sb_q.delete();
        end
        chk($sformatf("idle_busy_dut%0d", id), int'(busy_v[id]), 0);
    endtask

    initial begin
        sb_item_t it;
        a_v = 8'h00;
        b_v = 8'h00;
        sm = 1'b0;
        start_v = 3'b000;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_outs_dut%0d", i),
                int'({busy_v[i], done_v[i], lt_v[i], gt_v[i], eq_v[i]}), 0);
        #2 rst_n = 1'b1;

        // WIDTH=1 truth table, then sign-bit inversion
        issue(0, 8'h00, 8'h00, 1'b0, R_EQ, 1); wait_idle(0);
        issue(0, 8'h00, 8'h01, 1'b0, R_LT, 1); wait_idle(0);
        issue(0, 8'h01, 8'h00, 1'b0, R_GT, 1); wait_idle(0);
        issue(0, 8'h01, 8'h01, 1'b0, R_EQ, 1); wait_idle(0);
        issue(0, 8'h01, 8'h00, 1'b1, R_LT, 1); wait_idle(0);
        issue(0, 8'h00, 8'h01, 1'b1, R_GT, 1); wait_idle(0);

        // WIDTH=8 early exit
        issue(1, 8'hA5, 8'hA5, 1'b0, R_EQ, 8); wait_idle(1);
        issue(1, 8'h80, 8'h7F, 1'b0, R_GT, 1); wait_idle(1);
        issue(1, 8'h80, 8'h7F, 1'b1, R_LT, 1); wait_idle(1);
        issue(1, 8'h12, 8'h13, 1'b0, R_LT, 8); wait_idle(1);
        issue(1, 8'hFF, 8'h01, 1'b1, R_LT, 1); wait_idle(1);
        issue(1, 8'hF0, 8'hF8, 1'b1, R_LT, 5); wait_idle(1);

        // Back-to-back: start held through the done cycle
        @(negedge clk);
        a_v = 8'h80; b_v = 8'h00; sm = 1'b0; start_v = 3'b010;
        @(posedge clk); #1;
        it.id = 1; it.res = R_GT; it.edge_n = cyc + 1; sb_q.push_back(it);
        a_v = 8'h01; b_v = 8'h02;
        @(posedge clk); #1;
        @(posedge clk); #1;
        it.id = 1; it.res = R_LT; it.edge_n = cyc + 7; sb_q.push_back(it);
        start_v = 3'b000;
        wait_idle(1);

        // WIDTH=8 fixed latency, with an ignored mid-scan start
        issue(2, 8'h80, 8'h00, 1'b0, R_GT, 8);
        repeat (2) @(negedge clk);
        a_v = 8'h00; b_v = 8'hFF; sm = 1'b1; start_v = 3'b100;
        @(negedge clk);
        start_v = 3'b000;
        wait_idle(2);
        repeat (12) @(negedge clk);
        issue(2, 8'h12, 8'h13, 1'b0, R_LT, 8); wait_idle(2);
        issue(2, 8'h80, 8'h7F, 1'b1, R_LT, 8); wait_idle(2);
        issue(2, 8'h80, 8'h00, 1'b0, R_GT, 8); wait_idle(2);

        // Asynchronous reset three cycles into a scan; no done may follow
        @(negedge clk);
        a_v = 8'h00; b_v = 8'h80; sm = 1'b0; start_v = 3'b100;
        @(posedge clk); #1;
        start_v = 3'b000;
        repeat (3) @(posedge clk);
        chk("busy_before_reset", int'(busy_v[2]), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outs_dut2",
            int'({busy_v[2], done_v[2], lt_v[2], gt_v[2], eq_v[2]}), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(2, 8'h7F, 8'h7F, 1'b0, R_EQ, 8); wait_idle(2);
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
